// File: rtl/lfsr_err_monitor.sv
// PRBS/LFSR checker statistics: per-window, total and lock-loss error counters.
// Latency: every output is registered, one cycle after the sampling edge.
// Optional alarm: define LFSR_MON_ALARM_EN to build the sticky window-threshold alarm.
module lfsr_err_monitor #(
  parameter int WINDOW_LEN = 256,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_err,
  input  logic             i_lock,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_total_errs,
  output logic [15:0]      o_win_errs,
  output logic             o_win_done,
  output logic [7:0]       o_loss_cnt,
  output logic             o_alarm
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [15:0] LAST_BIT = 16'(WINDOW_LEN - 1);

  state_t           state_q, state_d;
  logic [15:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [15:0]      win_errs_q, win_errs_d;
  logic             win_done_q, win_done_d;
  logic [7:0]       loss_q, loss_d;

  logic        counted;
  logic        lock_lost;
  logic        lock_gained;
  logic        last_bit;
  logic [16:0] acc_sum;
  logic [15:0] acc_sat;

  // Qualify the current cycle: only bits seen while locked on both sides count.
  assign counted     = (state_q == LOCKED) && i_lock && i_valid;
  assign lock_lost   = (state_q == LOCKED) && !i_lock;
  assign lock_gained = (state_q == UNLOCKED) && i_lock;
  assign last_bit    = (bit_cnt_q == LAST_BIT);
  assign acc_sum     = {1'b0, acc_q} + {16'd0, i_err};
  assign acc_sat     = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];

`ifdef LFSR_MON_ALARM_EN
  localparam logic [16:0] THRESH = 17'(ERR_THRESH);
  logic alarm_q, alarm_d;
`endif

  // Next-state for counters; clear wins over counting, window close and lock loss.
  always_comb begin
    state_d    = i_lock ? LOCKED : UNLOCKED;
    bit_cnt_d  = bit_cnt_q;
    acc_d      = acc_q;
    total_d    = total_q;
    win_errs_d = win_errs_q;
    win_done_d = 1'b0;
    loss_d     = loss_q;
`ifdef LFSR_MON_ALARM_EN
    alarm_d    = alarm_q;
`endif
    if (i_clear) begin
      bit_cnt_d  = '0;
      acc_d      = '0;
      total_d    = '0;
      win_errs_d = '0;
      loss_d     = '0;
`ifdef LFSR_MON_ALARM_EN
      alarm_d    = 1'b0;
`endif
    end else if (counted) begin
      if (i_err && (total_q != {CNT_W{1'b1}})) begin
        total_d = total_q + 1'b1;
      end
      if (last_bit) begin
        win_errs_d = acc_sat;
        win_done_d = 1'b1;
        bit_cnt_d  = '0;
        acc_d      = '0;
`ifdef LFSR_MON_ALARM_EN
        if ({1'b0, acc_sat} >= THRESH) begin
          alarm_d = 1'b1;
        end
`endif
      end else begin
        bit_cnt_d = bit_cnt_q + 16'd1;
        acc_d     = acc_sat;
      end
    end else if (lock_lost) begin
      // Partial window is thrown away; no completion pulse.
      if (loss_q != 8'hFF) begin
        loss_d = loss_q + 8'd1;
      end
      bit_cnt_d = '0;
      acc_d     = '0;
    end else if (lock_gained) begin
      bit_cnt_d = '0;
      acc_d     = '0;
    end
  end

  // State and statistics registers; reset forces UNLOCKED and zero counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      bit_cnt_q  <= '0;
      acc_q      <= '0;
      total_q    <= '0;
      win_errs_q <= '0;
      win_done_q <= 1'b0;
      loss_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_q      <= acc_d;
      total_q    <= total_d;
      win_errs_q <= win_errs_d;
      win_done_q <= win_done_d;
      loss_q     <= loss_d;
    end
  end

`ifdef LFSR_MON_ALARM_EN
  // Sticky alarm register, released only by clear or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end
  assign o_alarm = alarm_q;
`else
  assign o_alarm = 1'b0;
`endif

  assign o_total_errs = total_q;
  assign o_win_errs   = win_errs_q;
  assign o_win_done   = win_done_q;
  assign o_loss_cnt   = loss_q;

endmodule

// File: tb/tb_lfsr_err_monitor.sv
// Bench for lfsr_err_monitor: directed steps, window results checked via a scoreboard.
// A second small instance (CNT_W=4) shares the stimulus for total-counter saturation.
// Alarm expectations follow LFSR_MON_ALARM_EN.
module tb_lfsr_err_monitor;

  localparam int WL = 256;
`ifdef LFSR_MON_ALARM_EN
  localparam logic ALARM_ON = 1'b1;
`else
  localparam logic ALARM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_err = 1'b0;
  logic        i_lock = 1'b0;
  logic        i_clear = 1'b0;
  logic [15:0] o_total_errs;
  logic [15:0] o_win_errs;
  logic        o_win_done;
  logic [7:0]  o_loss_cnt;
  logic        o_alarm;
  logic [3:0]  s_total_errs;
  logic [15:0] s_win_errs;
  logic        s_win_done;
  logic [7:0]  s_loss_cnt;
  logic        s_alarm;

  int checks = 0;
  int errors = 0;
  int wd_cnt = 0;
  int wd0;
  logic [15:0] exp_q[$];

  // Bench-side window model state
  logic m_locked = 1'b0;
  int   m_cnt = 0;
  int   m_acc = 0;

  lfsr_err_monitor #(.WINDOW_LEN(WL), .ERR_THRESH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_err(i_err), .i_lock(i_lock),
    .i_clear(i_clear), .o_total_errs(o_total_errs), .o_win_errs(o_win_errs),
    .o_win_done(o_win_done), .o_loss_cnt(o_loss_cnt), .o_alarm(o_alarm)
  );

  lfsr_err_monitor #(.WINDOW_LEN(4), .ERR_THRESH(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_err(i_err), .i_lock(i_lock),
    .i_clear(i_clear), .o_total_errs(s_total_errs), .o_win_errs(s_win_errs),
    .o_win_done(s_win_done), .o_loss_cnt(s_loss_cnt), .o_alarm(s_alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest expected window result.
  always @(posedge clk) begin
    #1;
    if (!rst && o_win_done) begin
      wd_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_win_done: observed pulse expected none (t=%0t)", $time);
      end
      if (exp_q.size() != 0) check("win_errs_sb", 32'(o_win_errs), 32'(exp_q.pop_front()));
    end
  end

  // Drive one cycle of stimulus (called at a negedge) and advance the model.
  task automatic step(input logic v, input logic e, input logic l, input logic c);
    i_valid = v; i_err = e; i_lock = l; i_clear = c;
    if (c) begin
      m_cnt = 0; m_acc = 0;
    end else if (m_locked && l && v) begin
      if (m_cnt == WL - 1) begin
        exp_q.push_back(16'(m_acc + int'(e)));
        m_cnt = 0; m_acc = 0;
      end else begin
        m_cnt++; m_acc += int'(e);
      end
    end else if (m_locked != l) begin
      m_cnt = 0; m_acc = 0;
    end
    m_locked = l;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_total", 32'(o_total_errs), 0);
    check("rst_win", 32'(o_win_errs), 0);
    check("rst_done", 32'(o_win_done), 0);
    check("rst_loss", 32'(o_loss_cnt), 0);
    check("rst_alarm", 32'(o_alarm), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Clean run: two windows with no errors
    step(0, 0, 1, 0);
    wd0 = wd_cnt;
    for (int i = 0; i < 2 * WL; i++) step(1, 0, 1, 0);
    check("clean_pulses", 32'(wd_cnt - wd0), 2);
    check("clean_win", 32'(o_win_errs), 0);
    check("clean_total", 32'(o_total_errs), 0);
    check("clean_loss", 32'(o_loss_cnt), 0);

    // Error burst: five errors in window 1, clean window 2
    step(0, 0, 1, 1);
    for (int i = 0; i < WL; i++) step(1, (i % 10 == 5) && (i < 50), 1, 0);
    check("burst_win", 32'(o_win_errs), 5);
    check("burst_total", 32'(o_total_errs), 5);
    check("burst_alarm", 32'(o_alarm), 32'(ALARM_ON));
    for (int i = 0; i < WL; i++) step(1, 0, 1, 0);
    check("burst_win2", 32'(o_win_errs), 0);
    check("burst_alarm_held", 32'(o_alarm), 32'(ALARM_ON));
    check("burst_total2", 32'(o_total_errs), 5);

    // Clear releases the alarm
    step(0, 0, 1, 1);
    check("clr_alarm", 32'(o_alarm), 0);
    check("clr_total", 32'(o_total_errs), 0);

    // Lock drop after 100 counted bits, then relock
    for (int i = 0; i < 100; i++) step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    check("drop_loss", 32'(o_loss_cnt), 1);
    step(0, 0, 1, 0);
    wd0 = wd_cnt;
    for (int i = 0; i < WL - 1; i++) step(1, 0, 1, 0);
    check("drop_no_early_done", 32'(wd_cnt - wd0), 0);
    step(1, 0, 1, 0);
    check("drop_done_after_256", 32'(wd_cnt - wd0), 1);

    // Clear coincident with the 256th bit
    wd0 = wd_cnt;
    for (int i = 0; i < WL - 1; i++) step(1, (i == 3), 1, 0);
    step(1, 1, 1, 1);
    check("clrw_done", 32'(o_win_done), 0);
    check("clrw_win", 32'(o_win_errs), 0);
    check("clrw_total", 32'(o_total_errs), 0);
    check("clrw_loss", 32'(o_loss_cnt), 0);
    check("clrw_pulses", 32'(wd_cnt - wd0), 0);
    for (int i = 0; i < WL; i++) step(1, 0, 1, 0);
    check("clrw_still_locked", 32'(wd_cnt - wd0), 1);

    // Saturation of total and loss counters
    step(0, 0, 1, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0);
    check("sat_total16", 32'(o_total_errs), 20);
    check("sat_total4", 32'(s_total_errs), 15);
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
    end
    check("sat_loss", 32'(o_loss_cnt), 255);
    check("sat_loss_s", 32'(s_loss_cnt), 255);

    // Unlocked traffic is ignored
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    wd0 = wd_cnt;
    for (int i = 0; i < 20; i++) step(i[0], 1, 0, 0);
    check("unl_total", 32'(o_total_errs), 0);
    check("unl_win", 32'(o_win_errs), 0);
    check("unl_loss", 32'(o_loss_cnt), 0);
    check("unl_pulses", 32'(wd_cnt - wd0), 0);

    // Asynchronous reset mid-window
    step(0, 0, 1, 0);
    for (int i = 0; i < 50; i++) step(1, (i % 5 == 0), 1, 0);
    check("mid_total", 32'(o_total_errs), 10);
    #2 rst = 1'b1;
    #1;
    check("arst_total", 32'(o_total_errs), 0);
    check("arst_loss", 32'(o_loss_cnt), 0);
    check("arst_win", 32'(o_win_errs), 0);
    m_locked = 1'b0; m_cnt = 0; m_acc = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 1, 0);
    wd0 = wd_cnt;
    for (int i = 0; i < WL; i++) step(1, (i == 0) || (i == WL - 1), 1, 0);
    check("post_rst_pulse", 32'(wd_cnt - wd0), 1);
    check("post_rst_win", 32'(o_win_errs), 2);
    check("post_rst_total", 32'(o_total_errs), 2);
    check("post_rst_loss", 32'(o_loss_cnt), 0);

    step(0, 0, 1, 0);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_err_monitor.md
LFSR_ERR_MONITOR -- requirements
Module: lfsr_err_monitor

Interface
REQ-001 Parameter WINDOW_LEN, default 256: number of valid locked bits per measurement window; legal range 2 to 65535.
REQ-002 Parameter ERR_THRESH, default 4: window error count at or above which the alarm fires.
REQ-003 Parameter CNT_W, default 16: width of the total error counter.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_valid  input  1  a checker bit is present this cycle.
REQ-007 i_err  input  1  checker mismatch flag for the current bit; qualified by i_valid.
REQ-008 i_lock  input  1  checker lock status; level signal.
REQ-009 i_clear  input  1  synchronous clear of all statistics.
REQ-010 o_total_errs  output  CNT_W  saturating count of errored bits seen while locked.
REQ-011 o_win_errs  output  16  error count of the last completed window.
REQ-012 o_win_done  output  1  one-cycle pulse when o_win_errs updates.
REQ-013 o_loss_cnt  output  8  saturating count of lock-loss events.
REQ-014 o_alarm  output  1  sticky window-threshold alarm.

Function
REQ-015 The FSM SHALL have two states: UNLOCKED and LOCKED; UNLOCKED to LOCKED when i_lock=1, LOCKED to UNLOCKED when i_lock=0, evaluated every cycle.
REQ-016 A bit SHALL be counted only when the state is LOCKED, i_lock=1 and i_valid=1 in the same cycle.
REQ-017 Each counted bit SHALL increment the window bit counter, and SHALL increment the window error accumulator and o_total_errs when i_err=1.
REQ-018 o_total_errs SHALL saturate at 2^CNT_W-1; o_loss_cnt SHALL saturate at 255.
REQ-019 On the WINDOW_LEN-th counted bit, o_win_errs SHALL load the accumulator plus that bit's i_err in the next cycle, with o_win_done=1 for exactly that cycle; the bit counter and accumulator SHALL restart at 0.
REQ-020 The window accumulator SHALL saturate at 65535.
REQ-021 A LOCKED to UNLOCKED transition SHALL increment o_loss_cnt once, and SHALL discard the partial window with no o_win_done pulse.
REQ-022 An UNLOCKED to LOCKED transition SHALL start a fresh window from zero.
REQ-023 When i_clear=1, the next edge SHALL zero o_total_errs, o_win_errs, o_loss_cnt, the window counters and o_alarm.
REQ-024 i_clear SHALL take priority over any count, window completion or loss event in the same cycle, and SHALL suppress o_win_done.
REQ-025 i_clear SHALL NOT change the FSM state.
REQ-026 i_err SHALL be ignored when i_valid=0.
REQ-027 All outputs SHALL be registered, with one-cycle latency from the sampling edge.

Reset
REQ-028 While rst=1, all outputs and counters SHALL be 0 and the state SHALL be UNLOCKED, independent of clk.
REQ-029 A reset asserted mid-window SHALL discard all statistics and SHALL NOT count as a lock loss.
REQ-030 After rst deasserts, the first counted bit SHALL be the first qualifying bit sampled on a rising edge.

Configuration
REQ-031 With LFSR_MON_ALARM_EN defined, o_alarm SHALL set on the o_win_done cycle when the new o_win_errs is at least ERR_THRESH, and SHALL stay set until i_clear or rst.
REQ-032 With LFSR_MON_ALARM_EN undefined, o_alarm SHALL be constant 0 and no threshold compare logic SHALL be synthesised.

Verification
REQ-033 Clean run: i_lock=1 with 512 valid bits, no errors, WINDOW_LEN=256 -> two o_win_done pulses, o_win_errs=0, o_total_errs=0, o_loss_cnt=0.
REQ-034 Error burst: 5 errors inside window 1 (ERR_THRESH=4, macro on) -> o_win_errs=5, o_total_errs=5, o_alarm=1 and held through a clean window 2.
REQ-035 Lock drop: i_lock falls after 100 counted bits, then relocks -> o_loss_cnt=1, no o_win_done, next o_win_done after 256 further bits.
REQ-036 i_clear issued on the same cycle as the 256th bit -> no o_win_done, all outputs 0 on the next cycle, state still LOCKED.
REQ-037 Saturation: CNT_W=4 with 20 errored bits -> o_total_errs=15; 300 lock drops -> o_loss_cnt=255.
REQ-038 Toggling i_valid with i_lock=0 and i_err=1 -> all counters stay 0; asynchronous rst mid-window -> outputs 0 immediately, o_loss_cnt unchanged at 0.
